// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM port between the instruction
// fetcher (4-byte reads), the load/store buffer (1/2/4-byte loads, optionally
// sign-extended) and ROB commit (1/2/4-byte stores).
// Multi-byte accesses are split into little-endian byte transactions.
// Priority is rob > slb > fetch. Each done output is a one-cycle pulse.
//
// Ports:
//   clk, rst (async, active-low), rdy (global freeze), in_misbranch (flush)
//   in_fetch_*   / out_fetch_*  : fetch request/address, done pulse + word
//   in_slb_*     / out_slb_*    : load request/address/size/signed, done + data
//   in_rob_*     / out_rob_done : store request/address/size/data, done pulse
//   in_ram_din, out_ram_addr, out_ram_dout, out_ram_wr : RAM byte port
//   in_io_buffer_full : stalls stores whose byte address is >= IO_BASE
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_misbranch,
  input  logic              in_fetch_req,
  input  logic [ADDR_W-1:0] in_fetch_addr,
  output logic              out_fetch_done,
  output logic [31:0]       out_fetch_data,
  input  logic              in_slb_req,
  input  logic [ADDR_W-1:0] in_slb_addr,
  input  logic [2:0]        in_slb_size,
  input  logic              in_slb_signed,
  output logic              out_slb_done,
  output logic [31:0]       out_slb_data,
  input  logic              in_rob_req,
  input  logic [ADDR_W-1:0] in_rob_addr,
  input  logic [2:0]        in_rob_size,
  input  logic [31:0]       in_rob_data,
  output logic              out_rob_done,
  input  logic [7:0]        in_ram_din,
  input  logic              in_io_buffer_full,
  output logic [ADDR_W-1:0] out_ram_addr,
  output logic [7:0]        out_ram_dout,
  output logic              out_ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              sgn_q, sgn_d;
  logic              own_slb_q, own_slb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              fetch_done_q, fetch_done_d;
  logic [31:0]       fetch_data_q, fetch_data_d;
  logic              slb_done_q, slb_done_d;
  logic [31:0]       slb_data_q, slb_data_d;
  logic              rob_done_q, rob_done_d;

  logic [31:0]       rd_merged;
  logic [ADDR_W-1:0] wr_addr;

  function automatic logic [2:0] norm_len(input logic [2:0] s);
    case (s)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] i);
    case (i[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] len,
                                         input logic sgn);
    case (len)
      3'd1:    return {{24{sgn & w[7]}}, w[7:0]};
      3'd2:    return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(IO_BASE);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    sgn_d        = sgn_q;
    own_slb_d    = own_slb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = 1'b0;
    fetch_done_d = 1'b0;
    fetch_data_d = fetch_data_q;
    slb_done_d   = 1'b0;
    slb_data_d   = slb_data_q;
    rob_done_d   = 1'b0;

    // The byte arriving this cycle belongs to the address issued one cycle
    // earlier, i.e. byte index cnt_q-1.
    rd_merged = rdata_q;
    case (cnt_q)
      3'd1:    rd_merged[7:0]   = in_ram_din;
      3'd2:    rd_merged[15:8]  = in_ram_din;
      3'd3:    rd_merged[23:16] = in_ram_din;
      3'd4:    rd_merged[31:24] = in_ram_din;
      default: ;
    endcase
    wr_addr = base_q + ADDR_W'(cnt_q);

    case (state_q)
      IDLE: begin
        // A done pulse on the output blocks any grant, so a request that is
        // still high in its own done cycle is not served a second time.
        if (!(fetch_done_q || slb_done_q || rob_done_q)) begin
          if (in_rob_req) begin
            state_d = WRITE;
            base_d  = in_rob_addr;
            len_d   = norm_len(in_rob_size);
            wdata_d = in_rob_data;
            if (is_io(in_rob_addr) && in_io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              ram_addr_d = in_rob_addr;
              ram_dout_d = in_rob_data[7:0];
              ram_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else if (!in_misbranch && (in_slb_req || in_fetch_req)) begin
            state_d = READ;
            cnt_d   = 3'd0;
            rdata_d = 32'd0;
            if (in_slb_req) begin
              base_d     = in_slb_addr;
              len_d      = norm_len(in_slb_size);
              sgn_d      = in_slb_signed;
              own_slb_d  = 1'b1;
              ram_addr_d = in_slb_addr;
            end else begin
              base_d     = in_fetch_addr;
              len_d      = 3'd4;
              sgn_d      = 1'b0;
              own_slb_d  = 1'b0;
              ram_addr_d = in_fetch_addr;
            end
          end
        end
      end

      READ: begin
        if (in_misbranch) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          rdata_d = rd_merged;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (own_slb_q) begin
              slb_done_d = 1'b1;
              slb_data_d = extend(rd_merged, len_q, sgn_q);
            end else begin
              fetch_done_d = 1'b1;
              fetch_data_d = rd_merged;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if ((cnt_q + 3'd1) < len_q) begin
              ram_addr_d = base_q + ADDR_W'(cnt_q + 3'd1);
            end
          end
        end
      end

      WRITE: begin
        if (cnt_q == len_q) begin
          rob_done_d = 1'b1;
          state_d    = IDLE;
          cnt_d      = 3'd0;
        end else if (!(is_io(wr_addr) && in_io_buffer_full)) begin
          ram_addr_d = wr_addr;
          ram_dout_d = byte_sel(wdata_q, cnt_q);
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      base_q       <= '0;
      sgn_q        <= 1'b0;
      own_slb_q    <= 1'b0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      ram_addr_q   <= '0;
      ram_dout_q   <= 8'd0;
      ram_wr_q     <= 1'b0;
      fetch_done_q <= 1'b0;
      fetch_data_q <= 32'd0;
      slb_done_q   <= 1'b0;
      slb_data_q   <= 32'd0;
      rob_done_q   <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      sgn_q        <= sgn_d;
      own_slb_q    <= own_slb_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
      fetch_done_q <= fetch_done_d;
      fetch_data_q <= fetch_data_d;
      slb_done_q   <= slb_done_d;
      slb_data_q   <= slb_data_d;
      rob_done_q   <= rob_done_d;
    end
  end

  assign out_fetch_done = fetch_done_q;
  assign out_fetch_data = fetch_data_q;
  assign out_slb_done   = slb_done_q;
  assign out_slb_data   = slb_data_q;
  assign out_rob_done   = rob_done_q;
  assign out_ram_addr   = ram_addr_q;
  assign out_ram_dout   = ram_dout_q;
  assign out_ram_wr     = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM model, reference memory model,
// scoreboard queues filled at stimulus time and a negedge monitor that
// pops and compares whenever the DUT pulses a done or writes a byte.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        in_misbranch = 1'b0;
  logic        in_fetch_req = 1'b0;
  logic [31:0] in_fetch_addr = 32'd0;
  logic        out_fetch_done;
  logic [31:0] out_fetch_data;
  logic        in_slb_req = 1'b0;
  logic [31:0] in_slb_addr = 32'd0;
  logic [2:0]  in_slb_size = 3'd0;
  logic        in_slb_signed = 1'b0;
  logic        out_slb_done;
  logic [31:0] out_slb_data;
  logic        in_rob_req = 1'b0;
  logic [31:0] in_rob_addr = 32'd0;
  logic [2:0]  in_rob_size = 3'd0;
  logic [31:0] in_rob_data = 32'd0;
  logic        out_rob_done;
  logic [7:0]  in_ram_din;
  logic        in_io_buffer_full = 1'b0;
  logic [31:0] out_ram_addr;
  logic [7:0]  out_ram_dout;
  logic        out_ram_wr;

  mem_arbiter #(.ADDR_W(ADDR_W), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_misbranch(in_misbranch),
    .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
    .out_fetch_done(out_fetch_done), .out_fetch_data(out_fetch_data),
    .in_slb_req(in_slb_req), .in_slb_addr(in_slb_addr), .in_slb_size(in_slb_size),
    .in_slb_signed(in_slb_signed), .out_slb_done(out_slb_done), .out_slb_data(out_slb_data),
    .in_rob_req(in_rob_req), .in_rob_addr(in_rob_addr), .in_rob_size(in_rob_size),
    .in_rob_data(in_rob_data), .out_rob_done(out_rob_done),
    .in_ram_din(in_ram_din), .in_io_buffer_full(in_io_buffer_full),
    .out_ram_addr(out_ram_addr), .out_ram_dout(out_ram_dout), .out_ram_wr(out_ram_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [31:0] data; } done_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  done_t fq[$];
  done_t sq[$];
  int    rq[$];
  wr_t   wq[$];

  logic [7:0] ref_mem [0:65535];

  function automatic logic [7:0] pat(input int unsigned a);
    logic [15:0] x;
    x = a[15:0];
    return (x[7:0] ^ {x[11:8], x[15:12]}) + 8'h3C;
  endfunction

  // Synchronous byte RAM (16-bit aliased), frozen by rdy like the DUT.
  initial begin
    logic [7:0] ram [0:65535];
    for (int i = 0; i < 65536; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (rdy) begin
        if (out_ram_wr) ram[out_ram_addr[15:0]] = out_ram_dout;
        else in_ram_din <= ram[out_ram_addr[15:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse and every RAM write is matched against the scoreboard.
  initial begin
    done_t e;
    wr_t   w;
    int    rc;
    forever begin
      @(negedge clk);
      if (rst && rdy) begin
        if (out_fetch_done) begin
          if (fq.size() == 0) chk("fetch_unexpected", 64'(out_fetch_done), 64'd0);
          else begin
            e = fq.pop_front();
            $display("cycle %0d fetch_done data=%08h", cyc, out_fetch_data);
            chk("fetch_data", 64'(out_fetch_data), 64'(e.data));
            chk("fetch_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (out_slb_done) begin
          if (sq.size() == 0) chk("slb_unexpected", 64'(out_slb_done), 64'd0);
          else begin
            e = sq.pop_front();
            $display("cycle %0d slb_done data=%08h", cyc, out_slb_data);
            chk("slb_data", 64'(out_slb_data), 64'(e.data));
            chk("slb_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (out_rob_done) begin
          if (rq.size() == 0) chk("rob_unexpected", 64'(out_rob_done), 64'd0);
          else begin
            rc = rq.pop_front();
            $display("cycle %0d rob_done", cyc);
            chk("rob_cycle", 64'(cyc), 64'(rc));
          end
        end
        if (out_ram_wr) begin
          if (wq.size() == 0) chk("ram_wr_unexpected", 64'(out_ram_wr), 64'd0);
          else begin
            w = wq.pop_front();
            $display("cycle %0d ram_write addr=%08h data=%02h", cyc, out_ram_addr, out_ram_dout);
            chk("ram_wr_addr", 64'(out_ram_addr), 64'(w.a));
            chk("ram_wr_data", 64'(out_ram_dout), 64'(w.d));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int norm(input logic [2:0] s);
    return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n, input bit sg);
    logic [31:0] w;
    logic [31:0] m;
    logic [15:0] ix;
    w = 32'd0;
    for (int b = 0; b < n; b++) begin
      ix = a[15:0] + 16'(b);
      w = w | (32'(ref_mem[ix]) << (8 * b));
    end
    if (n < 4) begin
      m = (32'h1 << (8 * n)) - 32'h1;
      if (sg && w[8 * n - 1]) w = w | ~m;
    end
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [15:0] ix;
    logic [7:0]  by;
    for (int b = 0; b < n; b++) begin
      ix = a[15:0] + 16'(b);
      by = 8'(d >> (8 * b));
      ref_mem[ix] = by;
      wq.push_back('{a + 32'(b), by});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int who, input string nm);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk);
      if (rst && rdy) begin
        case (who)
          0:       hit = out_fetch_done;
          1:       hit = out_slb_done;
          default: hit = out_rob_done;
        endcase
      end
      n++;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_100_cycles", nm);
    end
    step();
  endtask

  task automatic drv_fetch(input logic [31:0] a);
    in_fetch_addr = a;
    in_fetch_req  = 1'b1;
    wait_done(0, "fetch");
    in_fetch_req  = 1'b0;
  endtask

  task automatic drv_load(input logic [31:0] a, input logic [2:0] sz, input logic sg);
    in_slb_addr   = a;
    in_slb_size   = sz;
    in_slb_signed = sg;
    in_slb_req    = 1'b1;
    wait_done(1, "slb");
    in_slb_req    = 1'b0;
  endtask

  task automatic drv_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    in_rob_addr = a;
    in_rob_size = sz;
    in_rob_data = d;
    in_rob_req  = 1'b1;
    wait_done(2, "rob");
    in_rob_req  = 1'b0;
  endtask

  task automatic freeze(input int k);
    if (k > 0) begin
      step();
      rdy = 1'b0;
      repeat (k) @(posedge clk);
      #1;
      rdy = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int C, n, nr, ns, k, kind;
    logic [31:0] a, a2, a3, d;
    logic [2:0]  sz, sz2;
    logic        sg;
    logic [2:0]  szs [5];
    szs = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dones", 64'({out_fetch_done, out_slb_done, out_rob_done}), 64'd0);
    chk("rst_data", 64'({out_fetch_data, out_slb_data}), 64'd0);
    chk("rst_ram", 64'({out_ram_addr, out_ram_dout, out_ram_wr}), 64'd0);
    rdy = 1'b1;
    #2 rst = 1'b1;
    step();

    // Store the instruction bytes 13 05 00 00, then fetch them back
    C = cyc; ref_write(32'h1000, 4, 32'h00000513); rq.push_back(C + 5);
    drv_store(32'h1000, 3'd4, 32'h00000513);
    C = cyc; fq.push_back('{C + 6, ref_read(32'h1000, 4, 1'b0)});
    fork
      drv_fetch(32'h1000);
      begin
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
          @(negedge clk);
          chk("fetch_addr", 64'({out_ram_addr, out_ram_wr}), 64'({32'h1000 + 32'(b), 1'b0}));
        end
      end
    join
    chk("tp_fetch_word", 64'(out_fetch_data), 64'h00000513);

    // Byte 0x80 loaded signed / unsigned, halfword F234 loaded signed
    C = cyc; ref_write(32'h1100, 1, 32'h80); rq.push_back(C + 2);
    drv_store(32'h1100, 3'd1, 32'h00000080);
    C = cyc; sq.push_back('{C + 3, ref_read(32'h1100, 1, 1'b1)});
    drv_load(32'h1100, 3'd1, 1'b1);
    chk("tp_load_s8", 64'(out_slb_data), 64'hFFFFFF80);
    C = cyc; sq.push_back('{C + 3, ref_read(32'h1100, 1, 1'b0)});
    drv_load(32'h1100, 3'd1, 1'b0);
    chk("tp_load_u8", 64'(out_slb_data), 64'h00000080);
    C = cyc; ref_write(32'h1200, 2, 32'h0000F234); rq.push_back(C + 3);
    drv_store(32'h1200, 3'd2, 32'h0000F234);
    C = cyc; sq.push_back('{C + 4, ref_read(32'h1200, 2, 1'b1)});
    drv_load(32'h1200, 3'd2, 1'b1);
    chk("tp_load_s16", 64'(out_slb_data), 64'hFFFFF234);

    // Word store DEADBEEF
    C = cyc; ref_write(32'h2000, 4, 32'hDEADBEEF); rq.push_back(C + 5);
    drv_store(32'h2000, 3'd4, 32'hDEADBEEF);

    // All three requesters at once: rob, then slb, then fetch, each after a gap
    for (int t = 0; t < 3; t++) begin
      sz = szs[$urandom_range(0, 4)]; sz2 = szs[$urandom_range(0, 4)];
      nr = norm(sz); ns = norm(sz2); sg = 1'($urandom_range(0, 1));
      a = 32'(16'h3000 + 16'($urandom_range(0, 255)));
      a2 = a + 32'($urandom_range(0, 3)); a3 = 32'($urandom_range(0, 16'hFFF0));
      d = $urandom;
      C = cyc;
      ref_write(a, nr, d); rq.push_back(C + nr + 1);
      sq.push_back('{C + nr + 2 + ns + 2, ref_read(a2, ns, sg)});
      fq.push_back('{C + nr + 2 + ns + 3 + 6, ref_read(a3, 4, 1'b0)});
      fork
        drv_store(a, sz, d);
        drv_load(a2, sz2, sg);
        drv_fetch(a3);
      join
    end

    // I/O store stalled by a full buffer for three issuing edges
    C = cyc; d = $urandom; in_io_buffer_full = 1'b1;
    ref_write(32'h30000, 1, d); rq.push_back(C + 5);
    fork
      drv_store(32'h30000, 3'd1, d);
      begin
        step(); @(negedge clk); chk("io_stall_wr", 64'(out_ram_wr), 64'd0);
        step(); @(negedge clk); chk("io_stall_wr", 64'(out_ram_wr), 64'd0);
        step(); in_io_buffer_full = 1'b0;
        @(negedge clk); chk("io_stall_wr", 64'(out_ram_wr), 64'd0);
      end
    join
    // Stall hitting only the second byte, which crosses into the I/O region
    C = cyc; d = $urandom;
    ref_write(32'h2FFFF, 2, d); rq.push_back(C + 5);
    fork
      drv_store(32'h2FFFF, 3'd2, d);
      begin step(); in_io_buffer_full = 1'b1; step(); step(); in_io_buffer_full = 1'b0; end
    join

    // Misbranch in the second READ cycle aborts; a new fetch is granted next cycle
    C = cyc; in_fetch_addr = 32'h0500; in_fetch_req = 1'b1;
    step(); step(); in_misbranch = 1'b1;
    step(); in_misbranch = 1'b0; in_fetch_addr = 32'h0600;
    fq.push_back('{C + 9, ref_read(32'h0600, 4, 1'b0)});
    wait_done(0, "fetch_after_flush");
    in_fetch_req = 1'b0;
    // Misbranch with a fetch request in IDLE delays the grant by one cycle
    C = cyc; in_misbranch = 1'b1; fq.push_back('{C + 7, ref_read(32'h0700, 4, 1'b0)});
    fork drv_fetch(32'h0700); begin step(); in_misbranch = 1'b0; end join
    // Misbranch in the done cycle does not suppress the pulse
    C = cyc; fq.push_back('{C + 6, ref_read(32'h0800, 4, 1'b0)});
    fork drv_fetch(32'h0800); begin repeat (6) step(); in_misbranch = 1'b1; step(); in_misbranch = 1'b0; end join
    // Misbranch during a store has no effect
    C = cyc; d = $urandom; ref_write(32'h2400, 4, d); rq.push_back(C + 5);
    fork drv_store(32'h2400, 3'd4, d); begin step(); step(); in_misbranch = 1'b1; step(); in_misbranch = 1'b0; end join

    // Randomized single transactions with optional rdy freezes
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 16'hFFF8));
      sz = szs[$urandom_range(0, 4)]; n = norm(sz);
      sg = 1'($urandom_range(0, 1)); d = $urandom;
      k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      C = cyc;
      case (kind)
        0: begin
          fq.push_back('{C + 6 + k, ref_read(a, 4, 1'b0)});
          fork drv_fetch(a); freeze(k); join
        end
        1: begin
          sq.push_back('{C + n + 2 + k, ref_read(a, n, sg)});
          fork drv_load(a, sz, sg); freeze(k); join
        end
        default: begin
          ref_write(a, n, d); rq.push_back(C + n + 1 + k);
          fork drv_store(a, sz, d); freeze(k); join
        end
      endcase
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset in the middle of a fetch clears every output at once
    in_fetch_addr = 32'h0900; in_fetch_req = 1'b1;
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dones", 64'({out_fetch_done, out_slb_done, out_rob_done}), 64'd0);
    chk("mid_rst_fetch_data", 64'(out_fetch_data), 64'd0);
    chk("mid_rst_slb_data", 64'(out_slb_data), 64'd0);
    chk("mid_rst_ram", 64'({out_ram_addr, out_ram_dout, out_ram_wr}), 64'd0);
    in_fetch_req = 1'b0;
    step();
    #2 rst = 1'b1;
    step(); step();
    C = cyc; fq.push_back('{C + 6, ref_read(32'h0A00, 4, 1'b0)});
    drv_fetch(32'h0A00);
    repeat (10) step();

    chk("scoreboard_empty", 64'(fq.size() + sq.size() + rq.size() + wq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it among three requesters: instruction fetcher (4-byte reads), load/store buffer (1/2/4-byte loads, signed or unsigned) and ROB commit (1/2/4-byte stores).
- Splits each multi-byte access into little-endian byte transactions, reassembles and extends read data, and returns a one-cycle done pulse to the requester.
- Handles misbranch flush and stalls stores to the I/O region while the I/O buffer is full.

Parameters:
- ADDR_W, 32, width of requester addresses and out_ram_addr.
- IO_BASE, 32'h30000, addresses >= IO_BASE are I/O; stores there honour in_io_buffer_full.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
- rdy  input  1  global enable; 0 freezes all state and outputs.
- in_misbranch  input  1  pipeline flush.
- in_fetch_req  input  1  fetcher read request, held until done.
- in_fetch_addr  input  ADDR_W  fetch address.
- out_fetch_done  output  1  one-cycle pulse; out_fetch_data valid.
- out_fetch_data  output  32  instruction word.
- in_slb_req  input  1  load request, held until done.
- in_slb_addr  input  ADDR_W  load address.
- in_slb_size  input  3  1, 2 or 4 bytes.
- in_slb_signed  input  1  sign-extend the load result.
- out_slb_done  output  1  one-cycle pulse; out_slb_data valid.
- out_slb_data  output  32  extended load result.
- in_rob_req  input  1  committed-store request, held until done.
- in_rob_addr  input  ADDR_W  store address.
- in_rob_size  input  3  1, 2 or 4 bytes.
- in_rob_data  input  32  store data, low bytes used.
- out_rob_done  output  1  one-cycle pulse; store complete.
- in_ram_din  input  8  RAM read byte.
- in_io_buffer_full  input  1  I/O write buffer full.
- out_ram_addr  output  ADDR_W  RAM byte address.
- out_ram_dout  output  8  RAM write byte.
- out_ram_wr  output  1  1 = write, 0 = read.

Behaviour:
- Reset (rst=0): state IDLE, byte counter 0, every output 0.
- rdy=0: no register changes; the RAM is frozen by the same signal, so in-flight read data is preserved.
- States:
  - IDLE: grant at a clock edge only if some request is high and no done output is high in that cycle. This one-cycle gap prevents a still-asserted request from being served twice.
  - Priority: rob > slb > fetch.
  - On grant, latch address, size (fetch is 4; sizes other than 1/2 are treated as 4), signed flag, data and owner. Go to READ (slb/fetch) or WRITE (rob).
- READ, n bytes, request granted at the edge ending cycle C:
  - Byte b address (base+b) is driven in cycle C+1+b with out_ram_wr=0.
  - in_ram_din for byte b is valid in cycle C+2+b and is sampled at the end of that cycle into bits [8b+7:8b].
  - Owner's done pulses and data is valid in cycle C+n+2; state is IDLE in that cycle.
  - Fetch: 4-byte read, no extension.
  - Load, size 1: bits [31:8] = bit7 if signed, else 0.
  - Load, size 2: bits [31:16] = bit15 if signed, else 0.
- WRITE, n bytes:
  - Byte b is driven in cycle C+1+b with out_ram_addr=base+b, out_ram_dout=data[8b+7:8b], out_ram_wr=1.
  - out_rob_done pulses in cycle C+n+1 with out_ram_wr=0.
  - I/O stall: if the next byte's address >= IO_BASE and in_io_buffer_full=1 at the issuing edge, issue nothing (wr=0) and retry at the next edge. Following bytes shift by the stall length.
- Outside active byte cycles, out_ram_wr=0. out_ram_addr and out_ram_dout hold their last value.
- Done outputs are 0 except for their single pulse cycle. Data outputs hold until the next done for that owner.
- in_misbranch=1 (with rdy=1):
  - An active READ aborts: no done, state IDLE next cycle.
  - fetch/slb requests in that cycle are not granted.
  - A pending fetch/slb done pulse in that cycle is still emitted.
  - An active WRITE completes normally; a rob request may still be granted.
- Asynchronous reset mid-transfer abandons it immediately; no done is generated.

Test Plan:
- Fetch 0x1000, RAM bytes 13,05,00,00, no other requests → out_fetch_data=32'h00000513, done pulse in cycle C+6, addresses 0x1000..0x1003 with wr=0.
- Load size 1 signed from byte 0x80 → out_slb_data=32'hFFFFFF80. Same load unsigned → 32'h00000080. Size 2 signed on bytes 34,F2 → 32'hFFFFF234.
- Store size 4, 0x2000, data 32'hDEADBEEF → wr=1 with EF,BE,AD,DE at 0x2000..0x2003 in consecutive cycles; out_rob_done in cycle C+5.
- rob, slb and fetch raised in the same cycle → served in order rob, slb, fetch; each grant only after a one-cycle gap following the previous done.
- Store size 1 to 0x30000 with in_io_buffer_full=1 for 3 cycles → no wr for 3 cycles, then one write; done follows 1 cycle later.
- in_misbranch during cycle 2 of a fetch → no out_fetch_done, IDLE next cycle. in_misbranch during a store → store completes with done. rst pulsed low mid-read → all outputs 0 immediately.
